i2s_adc_receiver: RTL and testbench
===================================

Name: i2s_adc_receiver

Overview:
- I2S master receiver for the ADC side of the audio path. It is the capture counterpart of the DAC-side I2S transmitter.
- Runs on a single 12.288 MHz input_clk. Generates the ADC master clock, bit clock (serial_clk) and word_select, and deserialises sound_bit_in into signed 16-bit left/right samples.
- Delivers each stereo pair through a valid/ready handshake to the downstream processing chain, with a sticky overrun flag when a pair is dropped.

Parameters:
- SAMPLE_BITS, 16, bits per channel slot; frame length = 2*SAMPLE_BITS serial_clk periods.
- BCLK_DIV, 4, input_clk cycles per serial_clk period; must be even and >= 2. Default gives 3.072 MHz bit clock and 48 kHz frame rate.

Ports:
- input_clk  input  1  system clock, 12.288 MHz
- reset  input  1  asynchronous, active-low reset
- adc_mclk  output  1  ADC master clock, combinationally equal to input_clk
- serial_clk  output  1  I2S bit clock, registered
- word_select  output  1  I2S LR clock; 0 = left, 1 = right
- sound_bit_in  input  1  serial data from ADC; changes after serial_clk falls
- left_sample  output  SAMPLE_BITS  captured left word, two's complement
- right_sample  output  SAMPLE_BITS  captured right word
- sample_valid  output  1  stereo pair available
- sample_ready  input  1  consumer accepts pair
- overrun  output  1  sticky: a completed frame was dropped
- overrun_clear  input  1  clears overrun

Behaviour:
- Reset (reset=0, asynchronous):
  - div_cnt=0, serial_clk=0, slot=2*SAMPLE_BITS-1, word_select=0.
  - Shift registers, left_sample and right_sample are all 0.
  - sample_valid=0, overrun=0.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - Rise event: input_clk edge where div_cnt==BCLK_DIV/2-1; serial_clk<=1.
  - Fall event: edge where div_cnt==BCLK_DIV-1; serial_clk<=0.
  - serial_clk therefore has a 50% duty cycle and its first rise occurs BCLK_DIV/2 input_clk cycles after reset release.
- Slot counter:
  - Advances on each fall event: 2*SAMPLE_BITS-1 wraps to 0, otherwise increments.
  - On the same fall event: word_select<=0 when the new slot is 2*SAMPLE_BITS-1, and word_select<=1 when the new slot is SAMPLE_BITS-1.
  - This is I2S one-bit delay: word_select leads the MSB by one bit clock.
- Capture:
  - On each rise event, sound_bit_in is registered into the current slot.
  - Slots 0..SAMPLE_BITS-1 form the left word, MSB first. Slots SAMPLE_BITS..2*SAMPLE_BITS-1 form the right word, MSB first.
  - No sign manipulation is applied; bits are stored as received.
- Frame completion:
  - Occurs at the rise event in slot 2*SAMPLE_BITS-1 (right LSB).
  - The assembled pair is offered on the next input_clk edge, so sample_valid rises 1 input_clk cycle after that rise event.
  - The first complete frame after reset is delivered normally.
- Handshake:
  - A transfer occurs on any edge with sample_valid=1 and sample_ready=1.
  - On transfer with no new pair arriving: sample_valid<=0.
  - left_sample and right_sample hold stable while sample_valid=1.
  - At completion, if sample_valid=0 or a transfer occurs on the same edge: load the new pair and set sample_valid=1.
  - At completion, if sample_valid=1 with no transfer: the new pair is dropped, the held pair is unchanged, and overrun<=1.
- overrun:
  - Sticky until overrun_clear=1.
  - If set and clear occur on the same edge, set wins.
- sample_ready is ignored while sample_valid=0.
- Asserting reset mid-frame immediately returns all state to reset values. The partial frame is discarded and no sample_valid is produced for it.

Test Plan:
- Release reset and observe for 300 cycles:
  - serial_clk period 4 input_clk, first rise at cycle 2.
  - word_select high for exactly 64 input_clk (16 slots) per 128-cycle frame.
  - word_select falls at the fall event entering slot 31.
- Drive the ADC model with left=16'h7D00 and right=16'h8300, data changing on serial_clk fall, sample_ready tied 1:
  - left_sample=16'h7D00 and right_sample=16'h8300.
  - sample_valid is a 1-cycle pulse every 128 cycles.
- Hold sample_ready=0 for 3 frames with changing data (16'h0001/0002, 0003/0004, 0005/0006):
  - The first pair is held.
  - sample_valid stays 1.
  - overrun=1 after the second completion.
- With overrun=1, pulse overrun_clear at the same edge as another dropped completion: overrun remains 1. Pulse it alone: overrun=0.
- Assert sample_ready on exactly the completion edge while a pair is pending:
  - The old pair transfers and the new pair loads.
  - sample_valid stays 1.
  - No overrun.
- Assert reset at slot 20 mid-frame, release it, then send 16'h1234/16'hABCD:
  - All outputs read reset values during reset.
  - The first valid pair is 16'h1234/16'hABCD.
  - No spurious valid for the partial frame.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// I2S master receiver for the ADC capture path: generates mclk/bclk/lrclk and
// deserialises left/right words into a valid/ready stereo-pair interface.
module i2s_adc_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int BCLK_DIV    = 4
) (
  input  logic                   input_clk,
  input  logic                   reset,
  output logic                   adc_mclk,
  output logic                   serial_clk,
  output logic                   word_select,
  input  logic                   sound_bit_in,
  output logic [SAMPLE_BITS-1:0] left_sample,
  output logic [SAMPLE_BITS-1:0] right_sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  input  logic                   overrun_clear
);

  localparam int FRAME_BITS = 2 * SAMPLE_BITS;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SLOT_W     = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0]  RISE_CNT   = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  FALL_CNT   = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(FRAME_BITS - 1);
  localparam logic [SLOT_W-1:0] LEFT_LAST  = SLOT_W'(SAMPLE_BITS - 1);
  localparam logic [SLOT_W-1:0] FIRST_SLOT = '0;

  logic [DIV_W-1:0]       r_div;
  logic                   r_sclk;
  logic [SLOT_W-1:0]      r_slot;
  logic                   r_ws;
  logic [FRAME_BITS-1:0]  r_shift;
  logic                   r_armed;
  logic                   r_done;
  logic [SAMPLE_BITS-1:0] r_left;
  logic [SAMPLE_BITS-1:0] r_right;
  logic                   r_valid;
  logic                   r_overrun;

  logic                   w_rise;
  logic                   w_fall;
  logic [SLOT_W-1:0]      w_slot_next;
  logic                   w_xfer;
  logic                   w_drop;

  assign w_rise      = (r_div == RISE_CNT);
  assign w_fall      = (r_div == FALL_CNT);
  assign w_slot_next = (r_slot == LAST_SLOT) ? FIRST_SLOT : r_slot + SLOT_W'(1);
  assign w_xfer      = r_valid && sample_ready;
  assign w_drop      = r_done && r_valid && !sample_ready;

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
      r_slot <= LAST_SLOT;
      r_ws   <= 1'b0;
    end else begin
      r_div <= w_fall ? '0 : r_div + DIV_W'(1);
      if (w_rise) r_sclk <= 1'b1;
      if (w_fall) begin
        r_sclk <= 1'b0;
        r_slot <= w_slot_next;
        if (w_slot_next == LAST_SLOT) r_ws <= 1'b0;
        else if (w_slot_next == LEFT_LAST) r_ws <= 1'b1;
      end
    end
  end

  // The slot counter starts in the last slot, so the first rise after reset
  // lands in a right-LSB slot of a frame that never happened. r_armed blocks
  // completion until slot 0 has actually been captured.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rise) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], sound_bit_in};
        if (r_slot == FIRST_SLOT) r_armed <= 1'b1;
        if ((r_slot == LAST_SLOT) && r_armed) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_done && (!r_valid || w_xfer)) begin
        r_left  <= r_shift[FRAME_BITS-1:SAMPLE_BITS];
        r_right <= r_shift[SAMPLE_BITS-1:0];
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
      else if (overrun_clear) r_overrun <= 1'b0;
    end
  end

  assign adc_mclk     = input_clk;
  assign serial_clk   = r_sclk;
  assign word_select  = r_ws;
  assign left_sample  = r_left;
  assign right_sample = r_right;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: clock/word-select timing, capture,
// backpressure/overrun, same-edge handshake and mid-frame reset.
module tb_i2s_adc_receiver;

  logic        input_clk     = 1'b0;
  logic        reset         = 1'b0;
  logic        adc_mclk;
  logic        serial_clk;
  logic        word_select;
  logic        sound_bit_in  = 1'b0;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic        sample_ready  = 1'b1;
  logic        overrun;
  logic        overrun_clear = 1'b0;

  logic [15:0] adc_l = 16'h7D00;
  logic [15:0] adc_r = 16'h8300;
  logic [15:0] cur_l = 16'h0000;
  logic [15:0] cur_r = 16'h0000;
  int          m_slot = 31;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  i2s_adc_receiver #(.SAMPLE_BITS(16), .BCLK_DIV(4)) dut (
    .input_clk    (input_clk),
    .reset        (reset),
    .adc_mclk     (adc_mclk),
    .serial_clk   (serial_clk),
    .word_select  (word_select),
    .sound_bit_in (sound_bit_in),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clear(overrun_clear)
  );

  initial forever #5 input_clk = ~input_clk;

  // ADC model: new bit after every serial_clk fall; words latched at slot 0.
  initial begin
    forever begin
      @(negedge serial_clk or negedge reset);
      if (!reset) begin
        m_slot       = 31;
        sound_bit_in = 1'b0;
      end else begin
        m_slot = (m_slot == 31) ? 0 : m_slot + 1;
        if (m_slot == 0) begin
          cur_l = adc_l;
          cur_r = adc_r;
        end
        sound_bit_in = (m_slot < 16) ? cur_l[15 - m_slot] : cur_r[31 - m_slot];
      end
    end
  end

  task automatic tick();
    @(posedge input_clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sclk"},  32'(serial_clk),   32'd0);
    chk({tag, "_ws"},    32'(word_select),  32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_ovr"},   32'(overrun),      32'd0);
    chk({tag, "_left"},  32'(left_sample),  32'd0);
    chk({tag, "_right"}, 32'(right_sample), 32'd0);
  endtask

  initial begin
    logic exp_sclk, exp_ws, exp_v;

    repeat (3) tick();
    chk_reset_state("rst0");
    chk("mclk_follows_clk", 32'(adc_mclk), 32'(input_clk));

    @(posedge input_clk);
    #1;
    reset = 1'b1;
    cyc   = 0;

    // Free-running timing and the 7D00/8300 pair with ready tied high
    for (int e = 1; e <= 300; e++) begin
      tick();
      exp_sclk = ((cyc % 4) == 2) || ((cyc % 4) == 3);
      exp_ws   = (cyc >= 64) && (((cyc - 64) % 128) < 64);
      exp_v    = (cyc >= 131) && (((cyc - 131) % 128) == 0);
      chk("sclk", 32'(serial_clk), 32'(exp_sclk));
      chk("ws", 32'(word_select), 32'(exp_ws));
      chk("valid_pulse", 32'(sample_valid), 32'(exp_v));
      if (exp_v) begin
        chk("left_7D00", 32'(left_sample), 32'h7D00);
        chk("right_8300", 32'(right_sample), 32'h8300);
      end
    end
    chk("ovr_p1", 32'(overrun), 32'd0);

    // Backpressure over three frames
    adc_l = 16'h0001; adc_r = 16'h0002;
    goto(389);
    sample_ready = 1'b0;
    adc_l = 16'h0003; adc_r = 16'h0004;
    goto(514);
    chk("valid_before_f3", 32'(sample_valid), 32'd0);
    tick();
    chk("valid_f3", 32'(sample_valid), 32'd1);
    chk("left_0001", 32'(left_sample), 32'h0001);
    chk("right_0002", 32'(right_sample), 32'h0002);
    chk("ovr_f3", 32'(overrun), 32'd0);
    goto(520);
    adc_l = 16'h0005; adc_r = 16'h0006;
    goto(642);
    chk("ovr_before_drop", 32'(overrun), 32'd0);
    tick();
    chk("ovr_after_drop", 32'(overrun), 32'd1);
    chk("valid_held", 32'(sample_valid), 32'd1);
    chk("left_held", 32'(left_sample), 32'h0001);
    chk("right_held", 32'(right_sample), 32'h0002);

    // Clear coinciding with another drop, then clear alone
    goto(700);
    adc_l = 16'h0007; adc_r = 16'h0008;
    goto(770);
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    chk("left_held2", 32'(left_sample), 32'h0001);
    chk("right_held2", 32'(right_sample), 32'h0002);
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("valid_still", 32'(sample_valid), 32'd1);

    // Ready raised exactly on the completion edge
    goto(880);
    adc_l = 16'h5555; adc_r = 16'hAAAA;
    goto(898);
    sample_ready = 1'b1;
    tick();
    chk("valid_swap", 32'(sample_valid), 32'd1);
    chk("left_0007", 32'(left_sample), 32'h0007);
    chk("right_0008", 32'(right_sample), 32'h0008);
    chk("ovr_swap", 32'(overrun), 32'd0);
    tick();
    chk("valid_drained", 32'(sample_valid), 32'd0);

    // Reset in slot 20 of the 5555/AAAA frame
    goto(981);
    chk("ws_mid_frame", 32'(word_select), 32'd1);
    tick();
    reset = 1'b0;
    adc_l = 16'h1234; adc_r = 16'hABCD;
    #1;
    chk_reset_state("rst_mid");
    repeat (3) tick();
    chk_reset_state("rst_hold");
    @(posedge input_clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    for (int e = 1; e <= 130; e++) begin
      tick();
      chk("no_spurious_valid", 32'(sample_valid), 32'd0);
    end
    tick();
    chk("valid_after_rst", 32'(sample_valid), 32'd1);
    chk("left_1234", 32'(left_sample), 32'h1234);
    chk("right_ABCD", 32'(right_sample), 32'hABCD);
    chk("ovr_after_rst", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
